axi_mem_slave: RTL

AXI4 responder that terminates the master port produced by the core-bus-to-AXI bridge and serves it from an internal byte-strobed memory array. It accepts single-beat and INCR-burst reads and writes on independent read and write channels, and returns B and R responses with the request ID. It is used as the boot/data RAM target in simulation tops and small SoC configurations, where it replaces an interconnect and an external memory.

---
 rtl/amba_axi_pkg.sv | 63 ++++++
 rtl/nox_utils_pkg.sv | 15 +
 rtl/axi_mem_array.sv | 44 ++++
 rtl/axi_mem_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amba_axi_pkg.sv
// AXI4 type definitions shared by the memory slave and its bench.
package amba_axi_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ID_W   = 4;

    typedef logic [AXI_ADDR_W-1:0]   axi_addr_t;
    typedef logic [AXI_DATA_W-1:0]   axi_data_t;
    typedef logic [AXI_DATA_W/8-1:0] axi_wr_strb_t;
    typedef logic [AXI_ID_W-1:0]     axi_tid_t;
    typedef logic [7:0]              axi_alen_t;
    typedef logic [2:0]              axi_size_t;
    typedef logic [1:0]              axi_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef struct packed {
        axi_tid_t     awid;
        axi_addr_t    awaddr;
        axi_alen_t    awlen;
        axi_size_t    awsize;
        axi_burst_t   awburst;
        logic         awvalid;
        axi_data_t    wdata;
        axi_wr_strb_t wstrb;
        logic         wlast;
        logic         wvalid;
        logic         bready;
        axi_tid_t     arid;
        axi_addr_t    araddr;
        axi_alen_t    arlen;
        axi_size_t    arsize;
        axi_burst_t   arburst;
        logic         arvalid;
        logic         rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic      awready;
        logic      wready;
        axi_tid_t  bid;
        axi_resp_t bresp;
        logic      bvalid;
        logic      arready;
        axi_tid_t  rid;
        axi_data_t rdata;
        axi_resp_t rresp;
        logic      rlast;
        logic      rvalid;
    } s_axi_miso_t;

    // Byte increment for one beat of the given AxSIZE.
    function automatic axi_addr_t axi_size_bytes(input axi_size_t size);
        return axi_addr_t'(1) << size;
    endfunction

endpackage

// File: rtl/nox_utils_pkg.sv
// FSM state encodings for the AXI memory slave.
package nox_utils_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } axi_mem_wr_st_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } axi_mem_rd_st_t;

endpackage

// File: rtl/axi_mem_array.sv
// Single write port (byte enables) + single registered read port memory.
// A same-cycle read and write to one word returns the old contents.
module axi_mem_array #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH/8-1:0] i_wstrb,
    input  logic               i_re,
    input  logic [AW-1:0]      i_raddr,
    output logic [WIDTH-1:0]   o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Byte-enabled write; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(WIDTH / 8); b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register: loads only on request, so it holds across stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: single-beat and INCR bursts served from an internal RAM.
// Optional feature macro: AXI_MEM_OOR_ERR_EN (out-of-range beats give SLVERR
// instead of aliasing modulo the memory size).
module axi_mem_slave
    import amba_axi_pkg::*;
    import nox_utils_pkg::*;
#(
    parameter int unsigned MEM_KB    = 8,
    parameter axi_addr_t   BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o
);

    localparam int unsigned BYTES_W   = AXI_DATA_W / 8;
    localparam int unsigned ADDR_LSB  = $clog2(BYTES_W);
    localparam int unsigned DEPTH     = MEM_KB * 1024 / BYTES_W;
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam axi_addr_t   MEM_BYTES = axi_addr_t'(MEM_KB * 1024);

    // Write channel state
    axi_mem_wr_st_t r_wr_st, w_wr_st_d;
    axi_tid_t       r_wr_id, w_wr_id_d;
    axi_addr_t      r_wr_addr, w_wr_addr_d;
    axi_alen_t      r_wr_len, w_wr_len_d, r_wr_beat, w_wr_beat_d;
    axi_size_t      r_wr_size, w_wr_size_d;
    logic           r_wr_err, w_wr_err_d;
    axi_resp_t      r_bresp, w_bresp_d;
    logic           r_awready, w_awready_d, r_wready, w_wready_d, r_bvalid, w_bvalid_d;

    // Read channel state
    axi_mem_rd_st_t r_rd_st, w_rd_st_d;
    axi_tid_t       r_rd_id, w_rd_id_d;
    axi_addr_t      r_rd_addr, w_rd_addr_d;
    axi_alen_t      r_rd_len, w_rd_len_d, r_rd_beat, w_rd_beat_d;
    axi_size_t      r_rd_size, w_rd_size_d;
    logic           r_rd_oor, w_rd_oor_d;
    axi_resp_t      r_rresp, w_rresp_d;
    logic           r_rlast, w_rlast_d;
    logic           r_arready, w_arready_d, r_rvalid, w_rvalid_d;

    logic             w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic             w_wr_last_beat, w_wr_oor, w_rd_oor, w_mem_we, w_mem_re;
    axi_addr_t        w_wr_off, w_rd_addr_lkp, w_rd_off;
    logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
    axi_data_t        w_arr_rdata;
    logic             w_unused_bits;

    assign w_aw_hs = axi_mosi_i.awvalid && r_awready;
    assign w_w_hs  = axi_mosi_i.wvalid && r_wready;
    assign w_ar_hs = axi_mosi_i.arvalid && r_arready;
    assign w_r_hs  = r_rvalid && axi_mosi_i.rready;

    assign w_wr_off       = r_wr_addr - BASE_ADDR;
    assign w_wr_idx       = w_wr_off[ADDR_LSB +: IDX_W];
    assign w_wr_last_beat = (r_wr_beat == r_wr_len);

    // In IDLE the lookup address is the incoming AR; mid-burst it is the next beat.
    assign w_rd_addr_lkp = (r_rd_st == R_IDLE) ? axi_mosi_i.araddr
                                               : r_rd_addr + axi_size_bytes(r_rd_size);
    assign w_rd_off      = w_rd_addr_lkp - BASE_ADDR;
    assign w_rd_idx      = w_rd_off[ADDR_LSB +: IDX_W];

`ifdef AXI_MEM_OOR_ERR_EN
    assign w_wr_oor = (w_wr_off >= MEM_BYTES);
    assign w_rd_oor = (w_rd_off >= MEM_BYTES);
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    // Burst type is ignored (always INCR); upper offset bits only matter for range checks.
    assign w_unused_bits = ^{axi_mosi_i.awburst, axi_mosi_i.arburst, w_wr_off, w_rd_off};

    // Write FSM next state and registered outputs.
    always_comb begin
        w_wr_st_d   = r_wr_st;
        w_wr_id_d   = r_wr_id;
        w_wr_addr_d = r_wr_addr;
        w_wr_len_d  = r_wr_len;
        w_wr_beat_d = r_wr_beat;
        w_wr_size_d = r_wr_size;
        w_wr_err_d  = r_wr_err;
        w_bresp_d   = r_bresp;
        w_mem_we    = 1'b0;
        unique case (r_wr_st)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_wr_st_d   = W_DATA;
                    w_wr_id_d   = axi_mosi_i.awid;
                    w_wr_addr_d = axi_mosi_i.awaddr;
                    w_wr_len_d  = axi_mosi_i.awlen;
                    w_wr_size_d = axi_mosi_i.awsize;
                    w_wr_beat_d = '0;
                    w_wr_err_d  = 1'b0;
                end
            end
            W_DATA: begin
                if (w_w_hs) begin
                    w_mem_we    = !w_wr_oor;
                    w_wr_err_d  = r_wr_err || w_wr_oor;
                    w_wr_addr_d = r_wr_addr + axi_size_bytes(r_wr_size);
                    w_wr_beat_d = r_wr_beat + 8'd1;
                    // Whichever of wlast / final beat comes first closes the burst.
                    if (w_wr_last_beat || axi_mosi_i.wlast) begin
                        w_wr_st_d = W_RESP;
                        w_bresp_d = (w_wr_err_d || (axi_mosi_i.wlast != w_wr_last_beat))
                                    ? SLVERR : OKAY;
                    end
                end
            end
            W_RESP: begin
                if (r_bvalid && axi_mosi_i.bready) begin
                    w_wr_st_d = W_IDLE;
                end
            end
            default: w_wr_st_d = W_IDLE;
        endcase
        w_awready_d = (w_wr_st_d == W_IDLE);
        w_wready_d  = (w_wr_st_d == W_DATA);
        w_bvalid_d  = (w_wr_st_d == W_RESP);
    end

    // Read FSM next state and registered outputs.
    always_comb begin
        w_rd_st_d   = r_rd_st;
        w_rd_id_d   = r_rd_id;
        w_rd_addr_d = r_rd_addr;
        w_rd_len_d  = r_rd_len;
        w_rd_beat_d = r_rd_beat;
        w_rd_size_d = r_rd_size;
        w_rd_oor_d  = r_rd_oor;
        w_rresp_d   = r_rresp;
        w_rlast_d   = r_rlast;
        w_mem_re    = 1'b0;
        unique case (r_rd_st)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_st_d   = R_DATA;
                    w_rd_id_d   = axi_mosi_i.arid;
                    w_rd_addr_d = w_rd_addr_lkp;
                    w_rd_len_d  = axi_mosi_i.arlen;
                    w_rd_size_d = axi_mosi_i.arsize;
                    w_rd_beat_d = '0;
                    w_rlast_d   = (axi_mosi_i.arlen == 8'd0);
                    w_rd_oor_d  = w_rd_oor;
                    w_rresp_d   = w_rd_oor ? SLVERR : OKAY;
                    w_mem_re    = 1'b1;
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    if (r_rlast) begin
                        w_rd_st_d = R_IDLE;
                    end else begin
                        // Prefetch the next beat on the same edge: one beat per cycle.
                        w_rd_addr_d = w_rd_addr_lkp;
                        w_rd_beat_d = r_rd_beat + 8'd1;
                        w_rlast_d   = ((r_rd_beat + 8'd1) == r_rd_len);
                        w_rd_oor_d  = w_rd_oor;
                        w_rresp_d   = w_rd_oor ? SLVERR : OKAY;
                        w_mem_re    = 1'b1;
                    end
                end
            end
        endcase
        w_arready_d = (w_rd_st_d == R_IDLE);
        w_rvalid_d  = (w_rd_st_d == R_DATA);
    end

    // Write channel registers; readies stay low throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_st   <= W_IDLE;
            r_wr_id   <= '0;
            r_wr_addr <= '0;
            r_wr_len  <= '0;
            r_wr_beat <= '0;
            r_wr_size <= '0;
            r_wr_err  <= 1'b0;
            r_bresp   <= OKAY;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_wr_st   <= w_wr_st_d;
            r_wr_id   <= w_wr_id_d;
            r_wr_addr <= w_wr_addr_d;
            r_wr_len  <= w_wr_len_d;
            r_wr_beat <= w_wr_beat_d;
            r_wr_size <= w_wr_size_d;
            r_wr_err  <= w_wr_err_d;
            r_bresp   <= w_bresp_d;
            r_awready <= w_awready_d;
            r_wready  <= w_wready_d;
            r_bvalid  <= w_bvalid_d;
        end
    end

    // Read channel registers; readies stay low throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_st   <= R_IDLE;
            r_rd_id   <= '0;
            r_rd_addr <= '0;
            r_rd_len  <= '0;
            r_rd_beat <= '0;
            r_rd_size <= '0;
            r_rd_oor  <= 1'b0;
            r_rresp   <= OKAY;
            r_rlast   <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rd_st   <= w_rd_st_d;
            r_rd_id   <= w_rd_id_d;
            r_rd_addr <= w_rd_addr_d;
            r_rd_len  <= w_rd_len_d;
            r_rd_beat <= w_rd_beat_d;
            r_rd_size <= w_rd_size_d;
            r_rd_oor  <= w_rd_oor_d;
            r_rresp   <= w_rresp_d;
            r_rlast   <= w_rlast_d;
            r_arready <= w_arready_d;
            r_rvalid  <= w_rvalid_d;
        end
    end

    axi_mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (AXI_DATA_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (w_wr_idx),
        .i_wdata (axi_mosi_i.wdata),
        .i_wstrb (axi_mosi_i.wstrb),
        .i_re    (w_mem_re),
        .i_raddr (w_rd_idx),
        .o_rdata (w_arr_rdata)
    );

    // Slave-to-master bundle assembly.
    always_comb begin
        axi_miso_o         = '0;
        axi_miso_o.awready = r_awready;
        axi_miso_o.wready  = r_wready;
        axi_miso_o.bid     = r_wr_id;
        axi_miso_o.bresp   = r_bresp;
        axi_miso_o.bvalid  = r_bvalid;
        axi_miso_o.arready = r_arready;
        axi_miso_o.rid     = r_rd_id;
        axi_miso_o.rdata   = r_rd_oor ? '0 : w_arr_rdata;
        axi_miso_o.rresp   = r_rresp;
        axi_miso_o.rlast   = r_rlast;
        axi_miso_o.rvalid  = r_rvalid;
    end

endmodule
